// File: rtl/ddr_ring_pkg.sv
// Shared field layout, state encoding and helpers for the DDR ring scheduler.
// DataMover command/status word formats live here so both directions agree.
package ddr_ring_pkg;

    localparam int CMD_W    = 72;
    localparam int STS_W    = 8;
    localparam int ADDR_W   = 32;
    localparam int BTT_W    = 23;
    localparam int TAG_W    = 4;
    localparam int IDX_W    = 4;
    localparam int FILL_W   = 5;

    localparam int STS_OKAY_BIT = 7;
    localparam int STS_ERR_HI   = 6;
    localparam int STS_ERR_LO   = 4;
    localparam int STS_TAG_HI   = 3;
    localparam int STS_TAG_LO   = 0;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WAIT_STS,
        HALT
    } dir_state_t;

    // {rsvd, tag, saddr, drr/eof/dsa, type=incr, btt}
    function automatic logic [CMD_W-1:0] pack_cmd(
        input logic [TAG_W-1:0]  tag,
        input logic [ADDR_W-1:0] saddr,
        input logic [BTT_W-1:0]  btt
    );
        return {4'b0, tag, saddr, 8'b0, 1'b1, btt};
    endfunction

    function automatic logic sts_good(
        input logic [STS_W-1:0] sts,
        input logic [TAG_W-1:0] tag
    );
        return sts[STS_OKAY_BIT]
            && (sts[STS_ERR_HI:STS_ERR_LO] == 3'b000)
            && (sts[STS_TAG_HI:STS_TAG_LO] == tag);
    endfunction

endpackage

// File: rtl/ring_dir_ctrl.sv
// One DataMover direction: command FSM, buffer index, start address and
// sticky error, with a single command outstanding at a time.
module ring_dir_ctrl
    import ddr_ring_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [22:0] BUF_BYTES = 23'h00_1000,
    parameter int          NBUF      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              run,
    input  logic              can_issue,
    output logic [CMD_W-1:0]  cmd_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    input  logic [STS_W-1:0]  sts_data,
    input  logic              sts_valid,
    output logic              done,
    output logic              err
);

    dir_state_t          state;
    dir_state_t          next_state;
    logic [IDX_W-1:0]    idx;
    logic [ADDR_W-1:0]   saddr;
    logic                advance;
    logic                halt_now;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            saddr <= BASE_ADDR;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            // Running address avoids an index multiply; wrap reloads the base.
            if (advance) begin
                if (idx == IDX_W'(NBUF - 1)) begin
                    idx   <= '0;
                    saddr <= BASE_ADDR;
                end else begin
                    idx   <= idx + 1'b1;
                    saddr <= saddr + ADDR_W'(BUF_BYTES);
                end
            end
            if (halt_now) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        advance    = 1'b0;
        halt_now   = 1'b0;
        case (state)
            IDLE: begin
                if (sts_valid) begin
                    halt_now = 1'b1;
                end else if (enable && run && can_issue) begin
                    next_state = CMD;
                end
            end
            CMD: begin
                if (sts_valid) begin
                    halt_now = 1'b1;
                end else if (cmd_ready) begin
                    next_state = WAIT_STS;
                end
            end
            WAIT_STS: begin
                if (sts_valid) begin
                    if (sts_good(sts_data, idx)) begin
                        advance    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        halt_now = 1'b1;
                    end
                end
            end
            HALT: begin
                halt_now = sts_valid;
            end
            default: begin
                halt_now = 1'b1;
            end
        endcase
        if (halt_now) begin
            next_state = HALT;
        end
    end

    assign cmd_valid = (state == CMD);
    assign cmd_data  = pack_cmd(idx, saddr, BUF_BYTES);
    assign done      = advance;

endmodule

// File: rtl/ddr_ring_scheduler.sv
// Drives the AXI DataMover so DDR acts as a ring of NBUF buffers (deep FIFO).
// Define RING_STATS_EN to build the completed-buffer counters.
module ddr_ring_scheduler
    import ddr_ring_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [22:0] BUF_BYTES = 23'h00_1000,
    parameter int          NBUF      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic        m_axis_s2mm_cmdsts_aresetn,
    output logic [71:0] S_AXIS_S2MM_CMD_tdata,
    output logic        S_AXIS_S2MM_CMD_tvalid,
    input  logic        S_AXIS_S2MM_CMD_tready,
    input  logic [7:0]  M_AXIS_S2MM_STS_tdata,
    input  logic [0:0]  M_AXIS_S2MM_STS_tkeep,
    input  logic        M_AXIS_S2MM_STS_tlast,
    input  logic        M_AXIS_S2MM_STS_tvalid,
    output logic        M_AXIS_S2MM_STS_tready,
    output logic        m_axis_mm2s_cmdsts_aresetn,
    output logic [71:0] S_AXIS_MM2S_CMD_tdata,
    output logic        S_AXIS_MM2S_CMD_tvalid,
    input  logic        S_AXIS_MM2S_CMD_tready,
    input  logic [7:0]  M_AXIS_MM2S_STS_tdata,
    input  logic [0:0]  M_AXIS_MM2S_STS_tkeep,
    input  logic        M_AXIS_MM2S_STS_tlast,
    input  logic        M_AXIS_MM2S_STS_tvalid,
    output logic        M_AXIS_MM2S_STS_tready,
    output logic [4:0]  fill,
    output logic        s2mm_err,
    output logic        mm2s_err,
    output logic [31:0] s2mm_wr_count,
    output logic [31:0] mm2s_rd_count
);

    logic [15:0] rst_shift;
    logic        cmdsts_en;
    logic        s2mm_done;
    logic        mm2s_done;
    logic        unused_sts;

    // Holds the DataMover cmd/sts channels in reset for 16 cycles after ours.
    always_ff @(posedge clk) begin
        if (reset) begin
            rst_shift <= '1;
        end else begin
            rst_shift <= {rst_shift[14:0], 1'b0};
        end
    end

    assign cmdsts_en                  = ~rst_shift[15];
    assign m_axis_s2mm_cmdsts_aresetn = cmdsts_en;
    assign m_axis_mm2s_cmdsts_aresetn = cmdsts_en;
    assign M_AXIS_S2MM_STS_tready     = 1'b1;
    assign M_AXIS_MM2S_STS_tready     = 1'b1;
    assign unused_sts = ^{M_AXIS_S2MM_STS_tkeep, M_AXIS_S2MM_STS_tlast,
                          M_AXIS_MM2S_STS_tkeep, M_AXIS_MM2S_STS_tlast};

    ring_dir_ctrl #(
        .BASE_ADDR (BASE_ADDR),
        .BUF_BYTES (BUF_BYTES),
        .NBUF      (NBUF)
    ) u_s2mm (
        .clk       (clk),
        .reset     (reset),
        .enable    (cmdsts_en),
        .run       (run),
        .can_issue (fill < FILL_W'(NBUF)),
        .cmd_data  (S_AXIS_S2MM_CMD_tdata),
        .cmd_valid (S_AXIS_S2MM_CMD_tvalid),
        .cmd_ready (S_AXIS_S2MM_CMD_tready),
        .sts_data  (M_AXIS_S2MM_STS_tdata),
        .sts_valid (M_AXIS_S2MM_STS_tvalid),
        .done      (s2mm_done),
        .err       (s2mm_err)
    );

    // A buffer stays counted until its read status, so writes never overrun it.
    ring_dir_ctrl #(
        .BASE_ADDR (BASE_ADDR),
        .BUF_BYTES (BUF_BYTES),
        .NBUF      (NBUF)
    ) u_mm2s (
        .clk       (clk),
        .reset     (reset),
        .enable    (cmdsts_en),
        .run       (run),
        .can_issue (fill != '0),
        .cmd_data  (S_AXIS_MM2S_CMD_tdata),
        .cmd_valid (S_AXIS_MM2S_CMD_tvalid),
        .cmd_ready (S_AXIS_MM2S_CMD_tready),
        .sts_data  (M_AXIS_MM2S_STS_tdata),
        .sts_valid (M_AXIS_MM2S_STS_tvalid),
        .done      (mm2s_done),
        .err       (mm2s_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fill <= '0;
        end else if (s2mm_done && !mm2s_done) begin
            fill <= fill + 1'b1;
        end else if (mm2s_done && !s2mm_done) begin
            fill <= fill - 1'b1;
        end
    end

`ifdef RING_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            s2mm_wr_count <= '0;
            mm2s_rd_count <= '0;
        end else begin
            if (s2mm_done) begin
                s2mm_wr_count <= s2mm_wr_count + 1'b1;
            end
            if (mm2s_done) begin
                mm2s_rd_count <= mm2s_rd_count + 1'b1;
            end
        end
    end
`else
    assign s2mm_wr_count = 32'h0;
    assign mm2s_rd_count = 32'h0;
`endif

endmodule

// File: tb/tb_ddr_ring_scheduler.sv
// Directed bench for ddr_ring_scheduler: the bench plays the DataMover,
// accepting commands and returning status beats with hand-computed expectations.
module tb_ddr_ring_scheduler;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [22:0] BB   = 23'h00_1000;
    localparam bit          S2MM = 1'b0;
    localparam bit          MM2S = 1'b1;
`ifdef RING_STATS_EN
    localparam bit          STATS = 1'b1;
`else
    localparam bit          STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        s2mm_aresetn;
    logic [71:0] s2mm_cmd_data;
    logic        s2mm_cmd_valid;
    logic        s2mm_cmd_ready;
    logic [7:0]  s2mm_sts_data;
    logic [0:0]  s2mm_sts_keep;
    logic        s2mm_sts_last;
    logic        s2mm_sts_valid;
    logic        s2mm_sts_ready;
    logic        mm2s_aresetn;
    logic [71:0] mm2s_cmd_data;
    logic        mm2s_cmd_valid;
    logic        mm2s_cmd_ready;
    logic [7:0]  mm2s_sts_data;
    logic [0:0]  mm2s_sts_keep;
    logic        mm2s_sts_last;
    logic        mm2s_sts_valid;
    logic        mm2s_sts_ready;
    logic [4:0]  fill;
    logic        s2mm_err;
    logic        mm2s_err;
    logic [31:0] s2mm_wr_count;
    logic [31:0] mm2s_rd_count;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ddr_ring_scheduler #(
        .BASE_ADDR (BASE),
        .BUF_BYTES (BB),
        .NBUF      (8)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .run                        (run),
        .m_axis_s2mm_cmdsts_aresetn (s2mm_aresetn),
        .S_AXIS_S2MM_CMD_tdata      (s2mm_cmd_data),
        .S_AXIS_S2MM_CMD_tvalid     (s2mm_cmd_valid),
        .S_AXIS_S2MM_CMD_tready     (s2mm_cmd_ready),
        .M_AXIS_S2MM_STS_tdata      (s2mm_sts_data),
        .M_AXIS_S2MM_STS_tkeep      (s2mm_sts_keep),
        .M_AXIS_S2MM_STS_tlast      (s2mm_sts_last),
        .M_AXIS_S2MM_STS_tvalid     (s2mm_sts_valid),
        .M_AXIS_S2MM_STS_tready     (s2mm_sts_ready),
        .m_axis_mm2s_cmdsts_aresetn (mm2s_aresetn),
        .S_AXIS_MM2S_CMD_tdata      (mm2s_cmd_data),
        .S_AXIS_MM2S_CMD_tvalid     (mm2s_cmd_valid),
        .S_AXIS_MM2S_CMD_tready     (mm2s_cmd_ready),
        .M_AXIS_MM2S_STS_tdata      (mm2s_sts_data),
        .M_AXIS_MM2S_STS_tkeep      (mm2s_sts_keep),
        .M_AXIS_MM2S_STS_tlast      (mm2s_sts_last),
        .M_AXIS_MM2S_STS_tvalid     (mm2s_sts_valid),
        .M_AXIS_MM2S_STS_tready     (mm2s_sts_ready),
        .fill                       (fill),
        .s2mm_err                   (s2mm_err),
        .mm2s_err                   (mm2s_err),
        .s2mm_wr_count              (s2mm_wr_count),
        .mm2s_rd_count              (mm2s_rd_count)
    );

    function automatic logic [71:0] exp_cmd(input logic [3:0] tag, input logic [31:0] addr);
        return {4'h0, tag, addr, 8'h00, 1'b1, BB};
    endfunction

    function automatic logic cur_valid(input bit dir);
        return dir ? mm2s_cmd_valid : s2mm_cmd_valid;
    endfunction

    function automatic logic [71:0] cur_data(input bit dir);
        return dir ? mm2s_cmd_data : s2mm_cmd_data;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string name, input logic [71:0] observed,
                                input logic [71:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    task automatic check_reset_state(input string name);
        check_output({name, " s2mm_aresetn"}, 72'(s2mm_aresetn), 72'(0));
        check_output({name, " mm2s_aresetn"}, 72'(mm2s_aresetn), 72'(0));
        check_output({name, " s2mm_tvalid"}, 72'(s2mm_cmd_valid), 72'(0));
        check_output({name, " mm2s_tvalid"}, 72'(mm2s_cmd_valid), 72'(0));
        check_output({name, " fill"}, 72'(fill), 72'(0));
        check_output({name, " s2mm_err"}, 72'(s2mm_err), 72'(0));
        check_output({name, " mm2s_err"}, 72'(mm2s_err), 72'(0));
        check_output({name, " wr_count"}, 72'(s2mm_wr_count), 72'(0));
        check_output({name, " rd_count"}, 72'(mm2s_rd_count), 72'(0));
        check_output({name, " sts_tready"}, 72'({s2mm_sts_ready, mm2s_sts_ready}), 72'(3));
    endtask

    // Wait (bounded) for a command, check its word, then accept it for one cycle.
    task automatic apply_stimulus_cmd(input bit dir, input logic [31:0] addr,
                                      input logic [3:0] tag, input string name);
        int n = 0;
        while (!cur_valid(dir) && n < 24) begin
            tick();
            n++;
        end
        check_output({name, " tvalid"}, 72'(cur_valid(dir)), 72'(1));
        check_output({name, " tdata"}, cur_data(dir), exp_cmd(tag, addr));
        if (dir) mm2s_cmd_ready = 1'b1;
        else     s2mm_cmd_ready = 1'b1;
        tick();
        s2mm_cmd_ready = 1'b0;
        mm2s_cmd_ready = 1'b0;
        check_output({name, " tvalid drop"}, 72'(cur_valid(dir)), 72'(0));
    endtask

    task automatic apply_stimulus_sts(input bit dir, input logic [7:0] data);
        if (dir) begin
            mm2s_sts_data  = data;
            mm2s_sts_valid = 1'b1;
        end else begin
            s2mm_sts_data  = data;
            s2mm_sts_valid = 1'b1;
        end
        tick();
        s2mm_sts_valid = 1'b0;
        mm2s_sts_valid = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        run            = 1'b1;
        s2mm_cmd_ready = 1'b0;
        mm2s_cmd_ready = 1'b0;
        s2mm_sts_data  = 8'h00;
        mm2s_sts_data  = 8'h00;
        s2mm_sts_valid = 1'b0;
        mm2s_sts_valid = 1'b0;
        s2mm_sts_keep  = 1'b1;
        mm2s_sts_keep  = 1'b1;
        s2mm_sts_last  = 1'b1;
        mm2s_sts_last  = 1'b1;
        tick(3);
        check_reset_state("reset");

        // Reset stretcher: aresetn rises on the 16th cycle, first command one later.
        reset = 1'b0;
        tick(15);
        check_output("aresetn c15", 72'({s2mm_aresetn, mm2s_aresetn}), 72'(0));
        tick();
        check_output("aresetn c16", 72'({s2mm_aresetn, mm2s_aresetn}), 72'(3));
        check_output("s2mm tvalid c16", 72'(s2mm_cmd_valid), 72'(0));
        tick();
        check_output("s2mm tvalid c17", 72'(s2mm_cmd_valid), 72'(1));
        apply_stimulus_cmd(S2MM, 32'h0, 4'd0, "wr0");
        tick(3);
        check_output("no read before sts", 72'(mm2s_cmd_valid), 72'(0));
        apply_stimulus_sts(S2MM, 8'h80);
        check_output("fill after wr0", 72'(fill), 72'(1));
        check_output("mm2s tvalid same cycle", 72'(mm2s_cmd_valid), 72'(0));
        tick();
        check_output("mm2s launch", 72'(mm2s_cmd_valid), 72'(1));
        check_output("mm2s first word", mm2s_cmd_data, exp_cmd(4'd0, 32'h0));

        // Fill the ring with reads stalled.
        for (int i = 1; i < 8; i++) begin
            apply_stimulus_cmd(S2MM, 32'(i) * 32'h1000, 4'(i), "wr stream");
            apply_stimulus_sts(S2MM, 8'h80 | 8'(i));
            check_output("fill stream", 72'(fill), 72'(i + 1));
        end
        tick(4);
        check_output("no 9th write", 72'(s2mm_cmd_valid), 72'(0));
        check_output("fill full", 72'(fill), 72'(8));
        check_output("wr_count 8", 72'(s2mm_wr_count), 72'(STATS ? 32'd8 : 32'd0));
        check_output("rd_count 0", 72'(mm2s_rd_count), 72'(0));

        // First read frees a slot; the 9th write wraps to buffer 0.
        apply_stimulus_cmd(MM2S, 32'h0, 4'd0, "rd0");
        apply_stimulus_sts(MM2S, 8'h80);
        check_output("fill after rd0", 72'(fill), 72'(7));
        apply_stimulus_cmd(S2MM, 32'h0, 4'd0, "wr wrap");
        for (int j = 1; j < 5; j++) begin
            apply_stimulus_cmd(MM2S, 32'(j) * 32'h1000, 4'(j), "rd drain");
            apply_stimulus_sts(MM2S, 8'h80 | 8'(j));
            check_output("fill drain", 72'(fill), 72'(7 - j));
        end

        // Simultaneous good statuses at fill=3 leave fill unchanged.
        apply_stimulus_cmd(MM2S, 32'h5000, 4'd5, "rd5");
        s2mm_sts_data  = 8'h80;
        s2mm_sts_valid = 1'b1;
        apply_stimulus_sts(MM2S, 8'h85);
        check_output("fill both", 72'(fill), 72'(3));
        check_output("wr_count 9", 72'(s2mm_wr_count), 72'(STATS ? 32'd9 : 32'd0));
        check_output("rd_count 6", 72'(mm2s_rd_count), 72'(STATS ? 32'd6 : 32'd0));

        // SLVERR on a write halts S2MM only.
        apply_stimulus_cmd(S2MM, 32'h1000, 4'd1, "wr1 second lap");
        apply_stimulus_sts(S2MM, 8'hC1);
        check_output("s2mm_err slverr", 72'(s2mm_err), 72'(1));
        check_output("fill slverr", 72'(fill), 72'(3));
        check_output("wr_count held", 72'(s2mm_wr_count), 72'(STATS ? 32'd9 : 32'd0));
        tick(4);
        check_output("s2mm halted", 72'(s2mm_cmd_valid), 72'(0));
        for (int j = 6; j < 9; j++) begin
            apply_stimulus_cmd(MM2S, 32'(j % 8) * 32'h1000, 4'(j % 8), "rd after halt");
            apply_stimulus_sts(MM2S, 8'h80 | 8'(j % 8));
            check_output("fill after halt", 72'(fill), 72'(8 - j));
        end
        check_output("mm2s_err clean", 72'(mm2s_err), 72'(0));
        check_output("rd_count 9", 72'(mm2s_rd_count), 72'(STATS ? 32'd9 : 32'd0));
        tick(3);
        check_output("empty no read", 72'(mm2s_cmd_valid), 72'(0));
        apply_stimulus_sts(MM2S, 8'h81);
        check_output("stray sts in IDLE", 72'(mm2s_err), 72'(1));

        // Fresh start, then a tag mismatch on read index 4.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(16);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus_cmd(S2MM, 32'(i) * 32'h1000, 4'(i), "wr phase2");
            apply_stimulus_sts(S2MM, 8'h80 | 8'(i));
        end
        check_output("fill phase2", 72'(fill), 72'(5));
        apply_stimulus_cmd(S2MM, 32'h5000, 4'd5, "wr5 outstanding");
        for (int j = 0; j < 4; j++) begin
            apply_stimulus_cmd(MM2S, 32'(j) * 32'h1000, 4'(j), "rd phase2");
            apply_stimulus_sts(MM2S, 8'h80 | 8'(j));
            check_output("fill phase2 drain", 72'(fill), 72'(4 - j));
        end
        apply_stimulus_cmd(MM2S, 32'h4000, 4'd4, "rd4");
        apply_stimulus_sts(MM2S, 8'h85);
        check_output("mm2s_err tag", 72'(mm2s_err), 72'(1));
        check_output("fill tag err", 72'(fill), 72'(1));
        check_output("s2mm_err untouched", 72'(s2mm_err), 72'(0));
        tick(3);
        check_output("mm2s halted", 72'(mm2s_cmd_valid), 72'(0));

        // Reset while S2MM waits for status abandons everything.
        reset = 1'b1;
        tick();
        check_reset_state("mid reset");
        reset = 1'b0;
        tick(17);
        check_output("restart tvalid", 72'(s2mm_cmd_valid), 72'(1));
        check_output("restart word", s2mm_cmd_data, exp_cmd(4'd0, 32'h0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ddr_ring_scheduler.md
# ddr_ring_scheduler

Sequences the AXI DataMover so that DDR holds a ring of NBUF equal-size buffers used as a deep FIFO. Issues S2MM commands to fill buffers and MM2S commands to drain filled buffers in order. Checks every status beat and drives the DataMover command/status-channel resets. Sits between the system controller (run/flags) and the DataMover command and status AXI-Stream ports.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, DDR byte address of buffer 0
- BUF_BYTES, 23'h00_1000, bytes per buffer; also the BTT field of every command
- NBUF, 8, buffer count, legal range 2..16

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- run  in  1  level; 1 permits new commands
- m_axis_s2mm_cmdsts_aresetn  out  1  DataMover S2MM cmd/sts reset, active-low
- S_AXIS_S2MM_CMD_tdata / _tvalid / _tready  out/out/in  72/1/1  S2MM command stream
- M_AXIS_S2MM_STS_tdata / _tkeep / _tlast / _tvalid / _tready  in/in/in/in/out  8/1/1/1/1  S2MM status stream
- m_axis_mm2s_cmdsts_aresetn  out  1  MM2S cmd/sts reset, active-low
- S_AXIS_MM2S_CMD_tdata / _tvalid / _tready  out/out/in  72/1/1  MM2S command stream
- M_AXIS_MM2S_STS_tdata / _tkeep / _tlast / _tvalid / _tready  in/in/in/in/out  8/1/1/1/1  MM2S status stream
- fill  out  5  buffers written and not yet fully read, 0..NBUF
- s2mm_err, mm2s_err  out  1 each  sticky per-direction error
- s2mm_wr_count, mm2s_rd_count  out  32 each  completed-buffer counters (see Configuration)

## Operation
- Command word: {4'b0, tag[3:0], saddr[31:0], 8'b0, type=1, btt=BUF_BYTES}; tag = buffer index[3:0].
- Status beat: bit7 OKAY, bits6:4 SLVERR/DECERR/INTERR, bits3:0 tag. Beat is good iff bit7=1, bits6:4=0, tag = outstanding index. tkeep/tlast ignored.
- Both status tready tied 1.
- Per-direction FSM, one command outstanding per direction:
  - IDLE -> CMD when cmdsts_aresetn=1, run=1, and the direction condition holds (write: fill < NBUF; read: fill > 0).
  - CMD: tvalid=1, tdata stable; -> WAIT_STS on tvalid&tready.
  - WAIT_STS on status tvalid: good beat -> IDLE with index advanced; bad beat -> HALT with index not advanced and err set.
  - HALT persists until reset.
- Index wraps NBUF-1 -> 0. saddr is kept as a register, not a multiply: it adds BUF_BYTES on advance and loads BASE_ADDR on wrap. 32-bit addition is modulo 2^32.
- fill: +1 on good S2MM status, -1 on good MM2S status; unchanged if both occur in the same cycle. The buffer being read stays counted until its MM2S status, so it is never overwritten.
- run=0 blocks only IDLE->CMD. A command already in CMD stays valid until accepted; WAIT_STS completes normally.
- Status beat arriving in IDLE/CMD/HALT: discarded; sets that direction's err and moves it to HALT.
- Reset values:
  - all FSMs IDLE, indices 0, saddr BASE_ADDR, fill 0
  - errs 0, counters 0, cmd tvalid 0
  - both cmdsts_aresetn 0

## Timing
- cmdsts_aresetn: 16-bit shift register loaded all-ones while reset is high, shifting in 0 afterwards. Both aresetn outputs go 1 on the 16th cycle after reset deasserts.
- Command launch: tvalid rises the cycle after the IDLE condition is sampled true. Earliest first S2MM tvalid is 1 cycle after aresetn=1.
- tvalid is registered and drops the cycle after handshake. No combinational path from tready to tvalid.
- fill, err and counters update the cycle after the status beat.
- A read may launch 1 cycle after the fill 0->1 update.
- Reset mid-operation abandons outstanding commands. The DataMover is reset by aresetn in the same window, so no stale status is expected.

## Configuration
- RING_STATS_EN defined: s2mm_wr_count and mm2s_rd_count each increment by 1 per good status beat in their direction, wrapping at 2^32.
- RING_STATS_EN undefined: both outputs tied to 32'h0 and the counter registers are not built.

## Structure
- Package ddr_ring_pkg holds:
  - command and status field widths and bit positions
  - state enum {IDLE, CMD, WAIT_STS, HALT}
  - function packing the 72-bit command word
  - function classifying a status beat
- One sub-module, ring_dir_ctrl, instantiated twice (S2MM, MM2S). It contains the FSM, index, saddr and error logic. The top level holds fill, the reset stretcher and the stats counters.

## Test plan
- Reset release, run=1, tready=1: aresetn rises at cycle 16. The first S2MM command has saddr 0x0, tag 0, btt 0x1000. The MM2S command is not issued until S2MM OKAY tag 0 arrives.
- Stream NBUF=8 with MM2S tready=0: 8 S2MM commands at 0x0..0x7000, fill=8, no 9th command. Release MM2S: reads issue at 0x0 onward and fill drains to 0.
- Wrap: the 9th write after the first read completes uses saddr 0x0, tag 0.
- S2MM status 0xC0|tag (SLVERR): s2mm_err=1, S2MM halts, fill unchanged, MM2S continues draining.
- S2MM and MM2S good statuses in the same cycle at fill=3: fill stays 3.
- Tag mismatch (status 0x85 while index 4 is outstanding): mm2s_err=1. Reset mid-WAIT_STS: all outputs return to reset values.
